// File: rtl/cnt_seq.sv
// cnt_seq: two-requester job sequencer that preloads an external up-counter and runs it to terminal count
// Ports: clk; mr async active-low reset; reqN/startN job request and preload per requester (N=0,1);
//   gntN grant held for the whole job; doneN one-cycle terminal-count pulse; busy = not IDLE;
//   cnt_load_n/cnt_en/cnt_d drive the counter; cnt_q/cnt_co observe it (cnt_co high at 8'hFF).
// Build option: define CNT_SEQ_RR_EN for round-robin arbitration; default is fixed priority, req0 first.
module cnt_seq #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          mr,
    input  logic          req0,
    input  logic [CW-1:0] start0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic [CW-1:0] start1,
    output logic          gnt1,
    output logic          done1,
    output logic          busy,
    output logic          cnt_load_n,
    output logic          cnt_en,
    output logic [CW-1:0] cnt_d,
    input  logic [CW-1:0] cnt_q,
    input  logic          cnt_co
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state;
    logic sel;
    logic win;
    logic own_req;
    logic unused_cnt_q;
    assign unused_cnt_q = ^cnt_q;
    assign own_req = sel ? req1 : req0;
`ifdef CNT_SEQ_RR_EN
    logic last;
    // on a tie the requester not served last wins; otherwise whoever asks
    assign win = (req0 && req1) ? ~last : ~req0;
`else
    assign win = ~req0;
`endif
    // count until terminal count, then hold at all-ones
    assign cnt_en = (state == RUN) && !cnt_co;
    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            state      <= IDLE;
            sel        <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
            cnt_load_n <= 1'b1;
            cnt_d      <= '0;
`ifdef CNT_SEQ_RR_EN
            last       <= 1'b1;
`endif
        end else begin
            done0      <= 1'b0;
            done1      <= 1'b0;
            cnt_load_n <= 1'b1;
            case (state)
                IDLE: if (req0 || req1) begin
                    state      <= LOAD;
                    sel        <= win;
                    gnt0       <= ~win;
                    gnt1       <= win;
                    busy       <= 1'b1;
                    cnt_load_n <= 1'b0;
                    cnt_d      <= win ? start1 : start0;
`ifdef CNT_SEQ_RR_EN
                    last       <= win;
`endif
                end
                LOAD, RUN: if (!own_req) begin
                    // abort: granted requester withdrew, drop the job silently
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end else if (state == LOAD) begin
                    state <= RUN;
                end else if (cnt_co) begin
                    state <= DONE;
                    done0 <= ~sel;
                    done1 <= sel;
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnt_seq.sv
// tb_cnt_seq: randomized scoreboard bench for cnt_seq with an external up-counter model
module tb_cnt_seq;
    logic       clk = 1'b0;
    logic       mr;
    logic       req0, req1;
    logic [7:0] start0, start1;
    logic       gnt0, gnt1, done0, done1, busy, cnt_load_n, cnt_en;
    logic [7:0] cnt_d;
    logic [7:0] cnt_q = 8'h00;
    logic       cnt_co;

    cnt_seq #(.CW(8)) dut (
        .clk(clk), .mr(mr),
        .req0(req0), .start0(start0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .start1(start1), .gnt1(gnt1), .done1(done1),
        .busy(busy), .cnt_load_n(cnt_load_n), .cnt_en(cnt_en), .cnt_d(cnt_d),
        .cnt_q(cnt_q), .cnt_co(cnt_co)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!cnt_load_n) cnt_q <= cnt_d;
        else if (cnt_en) cnt_q <= cnt_q + 8'd1;
    assign cnt_co = (cnt_q == 8'hFF);

    typedef struct {
        bit is_done;
        bit who;
        int cyc;
        int start;
    } ev_t;
    ev_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit last = 1'b1;

    always @(posedge clk) cyc++;

    task automatic chk(input string n, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic push(input bit d, input bit w, input int c, input int s);
        ev_t e;
        e.is_done = d;
        e.who     = w;
        e.cyc     = c;
        e.start   = s;
        sb.push_back(e);
    endtask

    function automatic bit pick(input bit r0, input bit r1);
        if (!r0) return 1'b1;
        if (!r1) return 1'b0;
`ifdef CNT_SEQ_RR_EN
        return !last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // monitor: pops expected events whenever a grant rises or a done pulses
    bit pg0 = 0, pg1 = 0;
    int incs = 0;
    always @(negedge clk) begin
        ev_t e;
        if (gnt0 && gnt1) chk("one_gnt", 1, 0);
        if (cnt_en) incs++;
        if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
            incs = 0;
            if (sb.size() == 0) chk("gnt_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                chk("gnt_kind", 0, int'(e.is_done));
                chk("gnt_who", int'(gnt1), int'(e.who));
                chk("gnt_cyc", cyc, e.cyc);
                chk("gnt_cnt_d", int'(cnt_d), e.start);
                chk("gnt_load_n", int'(cnt_load_n), 0);
            end
        end
        if (done0 || done1) begin
            if (sb.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                chk("done_kind", 1, int'(e.is_done));
                chk("done_who", int'(done1), int'(e.who));
                chk("done_cyc", cyc, e.cyc);
                chk("done_cnt_q", int'(cnt_q), 255);
                chk("done_incs", incs, 255 - e.start);
            end
        end
        pg0 = gnt0;
        pg1 = gnt1;
    end

    // one job from an IDLE negedge; ab=1 withdraws the winner at a random point in LOAD/RUN
    task automatic job(input bit r0, input bit r1, input logic [7:0] s0, input logic [7:0] s1, input bit ab);
        bit w;
        int g, e, s;
        w = pick(r0, r1);
        last = w;
        s = w ? int'(s1) : int'(s0);
        req0 = r0; req1 = r1; start0 = s0; start1 = s1;
        g = cyc + 1;
        push(0, w, g, s);
        if (ab) e = g + int'($urandom_range(0, 256 - s));
        else begin
            e = g + 1 + 256 - s;
            push(1, w, e, s);
        end
        while (cyc < e) begin
            @(negedge clk);
            if (cyc < e) begin
                start0 = 8'($urandom);
                start1 = 8'($urandom);
                if (w) req0 = 1'($urandom);
                else req1 = 1'($urandom);
            end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        chk("end_gnt", int'({gnt1, gnt0}), 0);
        chk("end_busy", int'(busy), 0);
        chk("end_cnt_en", int'(cnt_en), 0);
        if (!ab) chk("hold_ff", int'(cnt_q), 255);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, d;
        bit w;
        mr = 0; req0 = 1; req1 = 0; start0 = 8'hEE; start1 = 8'h00;
        repeat (10) begin
            @(negedge clk);
            chk("rst_gnt0", int'(gnt0), 0);
            chk("rst_load_n", int'(cnt_load_n), 1);
            chk("rst_cnt_en", int'(cnt_en), 0);
            chk("rst_busy", int'(busy), 0);
        end
        mr = 1;
        job(1, 0, 8'hEE, 8'h00, 0);
        job(0, 1, 8'h00, 8'hFF, 0);

        // contention with both requests held across four jobs
        req0 = 1; req1 = 1; start0 = 8'hFC; start1 = 8'hFC;
        g = cyc + 1;
        d = 0;
        for (int k = 0; k < 4; k++) begin
            w = pick(1, 1);
            last = w;
            push(0, w, g, 'hFC);
            d = g + 5;
            push(1, w, d, 'hFC);
            g = d + 2;
        end
        wait_until(d);
        req0 = 0; req1 = 0;
        @(negedge clk);
        chk("cont_busy", int'(busy), 0);

        // abort three cycles into RUN with req1 pending
        req0 = 1; req1 = 0; start0 = 8'h10; start1 = 8'hF0;
        g = cyc + 1;
        last = 0;
        push(0, 0, g, 'h10);
        wait_until(g + 1);
        req1 = 1;
        wait_until(g + 3);
        req0 = 0;
        @(negedge clk);
        chk("abort_gnt0", int'(gnt0), 0);
        chk("abort_cnt_en", int'(cnt_en), 0);
        chk("abort_busy", int'(busy), 0);
        last = 1;
        push(0, 1, g + 5, 'hF0);
        push(1, 1, g + 5 + 1 + 16, 'hF0);
        wait_until(g + 22);
        req1 = 0;
        @(negedge clk);

        // reset in the middle of RUN, then a full-length job
        req0 = 1; start0 = 8'($urandom_range('h80, 'hF0));
        g = cyc + 1;
        last = 0;
        push(0, 0, g, int'(start0));
        wait_until(g + 3);
        #2 mr = 0;
        #1;
        chk("mrst_gnt0", int'(gnt0), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_cnt_en", int'(cnt_en), 0);
        chk("mrst_load_n", int'(cnt_load_n), 1);
        chk("mrst_cnt_d", int'(cnt_d), 0);
        last = 1;
        start0 = 8'h00;
        @(negedge clk);
        chk("mrst_hold", int'({gnt1, gnt0, busy}), 0);
        mr = 1;
        g = cyc + 1;
        push(0, 0, g, 0);
        push(1, 0, g + 257, 0);
        wait_until(g + 257);
        req0 = 0;
        @(negedge clk);
        chk("long_busy", int'(busy), 0);

        for (int k = 0; k < 20; k++) begin
            int m;
            m = int'($urandom_range(1, 3));
            job(m[0], m[1], 8'($urandom_range('hE0, 'hFF)), 8'($urandom_range('hE0, 'hFF)),
                $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cnt_seq.md
CNT_SEQ -- requirements
Module: cnt_seq

Interface
REQ-001 Parameter: CW, 8, counter data width; only the value 8 is supported.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 mr  input  1  master reset; asynchronous, active-low.
REQ-004 req0  input  1  requester 0 job request; held high until done0 or abort.
REQ-005 start0  input  CW  requester 0 preload value; sampled only at grant.
REQ-006 gnt0  output  1  counter granted to requester 0.
REQ-007 done0  output  1  one-cycle pulse: requester 0 job reached terminal count.
REQ-008 req1, start1, gnt1, done1: same widths and meaning for requester 1.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 cnt_load_n  output  1  counter synchronous load, active-low.
REQ-011 cnt_en  output  1  counter count enable, active-high.
REQ-012 cnt_d  output  CW  counter preload data.
REQ-013 cnt_q  input  CW  counter value, observed for debug/verification only.
REQ-014 cnt_co  input  1  counter carry-out; high when cnt_q == 8'hFF.

Function
REQ-015 FSM states: IDLE, LOAD, RUN, DONE; all outputs registered or decoded from state only, except cnt_en.
REQ-016 IDLE: if any req is high at the edge, the FSM grants the winner, latches its start value into cnt_d, sets its gnt and moves to LOAD; otherwise it stays in IDLE.
REQ-017 LOAD: lasts one cycle with cnt_load_n=0 and cnt_en=0; the next state is RUN.
REQ-018 RUN: cnt_load_n=1 and cnt_en = ~cnt_co, so the counter holds at 8'hFF; in a cycle with cnt_co=1 the next state is DONE.
REQ-019 RUN length = 256 - start cycles; start=8'hFF gives one RUN cycle with zero increments.
REQ-020 DONE: lasts one cycle with the granted requester's done high; gnt is cleared and the next state is IDLE.
REQ-021 The first done pulse after gnt rises occurs exactly 1 + (256 - start) cycles later.
REQ-022 gnt is held continuously through LOAD, RUN and DONE; at most one gnt is high at a time.
REQ-023 Abort: if the granted req goes low in LOAD or RUN, the FSM goes to IDLE at the next edge with gnt=0 and no done; cnt_en is 0 from that edge.
REQ-024 A req still high in IDLE after its done is treated as a new job.
REQ-025 IDLE always lasts at least one cycle between jobs.
REQ-026 Changes to start or to a non-granted req during a job are ignored.

Reset
REQ-027 mr low forces the following immediately, without waiting for clk: state=IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, cnt_load_n=1, cnt_en=0, cnt_d=0, round-robin pointer = "last served 1".
REQ-028 mr asserted mid-job abandons the job without a done pulse.
REQ-029 After mr deasserts, the first grant occurs no earlier than the first rising edge with mr high.

Configuration
REQ-030 Macro CNT_SEQ_RR_EN: when defined, simultaneous requests in IDLE are granted round-robin (the requester not last served wins); the pointer updates on every grant.
REQ-031 Without CNT_SEQ_RR_EN, arbitration is fixed-priority with req0 always winning over req1.

Verification
REQ-032 Reset: mr=0 for 100 ns with req0=1 -> gnt0=0, cnt_load_n=1, cnt_en=0, busy=0 throughout.
REQ-033 Single job: req0=1, start0=8'hEE -> one LOAD cycle with cnt_d=8'hEE; cnt_q counts EE..FF; done0 pulses 19 cycles after gnt0 rises; cnt_q stays 8'hFF.
REQ-034 Edge value: req1=1, start1=8'hFF -> RUN lasts 1 cycle; done1 pulses 2 cycles after gnt1 rises; counter never increments.
REQ-035 Contention: req0=req1=1 held, both starts 8'hFC -> with CNT_SEQ_RR_EN the grants alternate 0,1,0,1; without it gnt0 wins every job.
REQ-036 Abort: req0 drops 3 cycles into RUN -> next edge gnt0=0, cnt_en=0, no done0; a pending req1 is granted after one IDLE cycle.
REQ-037 Reset mid-run: mr=0 during RUN -> immediate IDLE, no done; after release, a new req0 with start0=8'h00 completes in 257 cycles.
